// File: rtl/digit_entry_ctrl_if.sv
// -----------------------------------------------------------------------------
// digit_entry_ctrl_if
// Purpose : Groups the key-entry handshake and the committed-number result bus
//           of digit_entry_ctrl.
// Signals : key_in[9:0]      one-hot decimal key (bit k = digit k)
//           key_valid        key held down (level)
//           key_ready        controller can accept a key this cycle
//           clear            discard entry in progress, clear err
//           enter            commit current entry
//           num_out[4*NDIG]  last committed packed code, MS digit in top nibble
//           num_valid        one-cycle pulse when num_out updates
//           digit_cnt[3:0]   digits held in the entry register
//           err              sticky: a non-one-hot key was accepted
// Modports: master drives keys/controls, slave is the controller.
// -----------------------------------------------------------------------------
interface digit_entry_ctrl_if #(
  parameter int NDIG = 4
);
  logic [9:0]        key_in;
  logic              key_valid;
  logic              key_ready;
  logic              clear;
  logic              enter;
  logic [4*NDIG-1:0] num_out;
  logic              num_valid;
  logic [3:0]        digit_cnt;
  logic              err;

  modport master (
    output key_in, key_valid, clear, enter,
    input  key_ready, num_out, num_valid, digit_cnt, err
  );

  modport slave (
    input  key_in, key_valid, clear, enter,
    output key_ready, num_out, num_valid, digit_cnt, err
  );
endinterface

// File: rtl/digit_entry_ctrl.sv
// -----------------------------------------------------------------------------
// digit_entry_ctrl
// Purpose : Accumulates up to NDIG decimal digits from a one-hot keypad into a
//           packed entry register and commits it to num_out on enter.
//           Each key press must be released before the next one is taken.
// Ports   : clk    rising-edge clock
//           rst_n  synchronous active-low reset
//           bus    digit_entry_ctrl_if.slave (key handshake + result bus)
// Config  : EXCESS3_EN defined   -> digit k coded as k+3, empty code 4'b0011
//           EXCESS3_EN undefined -> digit k coded as BCD k, empty code 4'b0000
// -----------------------------------------------------------------------------
module digit_entry_ctrl #(
  parameter int NDIG = 4
) (
  input logic               clk,
  input logic               rst_n,
  digit_entry_ctrl_if.slave bus
);

  localparam int W = 4 * NDIG;

`ifdef EXCESS3_EN
  localparam logic [3:0] EMPTY_CODE = 4'd3;
  localparam int         CODE_OFS   = 3;
`else
  localparam logic [3:0] EMPTY_CODE = 4'd0;
  localparam int         CODE_OFS   = 0;
`endif

  localparam logic [W-1:0] EMPTY_ENTRY = {NDIG{EMPTY_CODE}};
  localparam logic [3:0]   CNT_FULL    = 4'(NDIG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_HOLD,
    S_FULL,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_entry;
  logic [3:0]     r_cnt;
  logic           r_err;
  logic [W-1:0]   r_num_out;
  logic           r_num_valid;

  state_t         w_state_next;
  logic [W-1:0]   w_entry_next;
  logic [3:0]     w_cnt_next;
  logic           w_err_next;
  logic [W-1:0]   w_num_out_next;
  logic           w_num_valid_next;

  logic           w_key_ready;
  logic           w_handshake;
  logic           w_onehot;
  logic [3:0]     w_code;
  state_t         w_hold_or_idle;
  state_t         w_release_target;

  assign w_key_ready = (r_state == S_IDLE) || (r_state == S_ARMED);
  assign w_handshake = bus.key_valid && w_key_ready;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign w_onehot = (bus.key_in != 10'd0) &&
                    ((bus.key_in & (bus.key_in - 10'd1)) == 10'd0);

  // Digit encoder; only meaningful when w_onehot is true.
  always_comb begin
    w_code = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (bus.key_in[k]) begin
        w_code = w_code | 4'(k + CODE_OFS);
      end
    end
  end

  // After clear or commit, a still-held key must be released before the next
  // digit, so park in HOLD instead of IDLE.
  assign w_hold_or_idle = bus.key_valid ? S_HOLD : S_IDLE;

  always_comb begin
    if (r_cnt == CNT_FULL) begin
      w_release_target = S_FULL;
    end else if (r_cnt == 4'd0) begin
      w_release_target = S_IDLE;
    end else begin
      w_release_target = S_ARMED;
    end
  end

  // Next-state and datapath. Priority: clear > enter > key handshake.
  always_comb begin
    w_state_next     = r_state;
    w_entry_next     = r_entry;
    w_cnt_next       = r_cnt;
    w_err_next       = r_err;
    w_num_out_next   = r_num_out;
    w_num_valid_next = 1'b0;

    if (bus.clear) begin
      w_entry_next = EMPTY_ENTRY;
      w_cnt_next   = 4'd0;
      w_err_next   = 1'b0;
      w_state_next = w_hold_or_idle;
    end else begin
      case (r_state)
        S_IDLE, S_ARMED: begin
          if (bus.enter) begin
            // Enter with nothing typed is ignored; the key is dropped either way.
            if (r_state == S_ARMED) begin
              w_state_next = S_DONE;
            end
          end else if (w_handshake) begin
            if (w_onehot) begin
              w_entry_next = (r_entry << 4) | W'(w_code);
              w_cnt_next   = r_cnt + 4'd1;
            end else begin
              w_err_next = 1'b1;
            end
            w_state_next = S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.enter) begin
            w_state_next = S_DONE;
          end else if (!bus.key_valid) begin
            w_state_next = w_release_target;
          end
        end
        S_FULL: begin
          if (bus.enter) begin
            w_state_next = S_DONE;
          end
        end
        S_DONE: begin
          // num_valid is registered so it rises together with the new num_out;
          // a reset during DONE therefore yields no pulse.
          w_num_out_next   = r_entry;
          w_num_valid_next = 1'b1;
          w_entry_next     = EMPTY_ENTRY;
          w_cnt_next       = 4'd0;
          w_state_next     = w_hold_or_idle;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_entry     <= EMPTY_ENTRY;
      r_cnt       <= 4'd0;
      r_err       <= 1'b0;
      r_num_out   <= EMPTY_ENTRY;
      r_num_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_entry     <= w_entry_next;
      r_cnt       <= w_cnt_next;
      r_err       <= w_err_next;
      r_num_out   <= w_num_out_next;
      r_num_valid <= w_num_valid_next;
    end
  end

  assign bus.key_ready = w_key_ready;
  assign bus.num_out   = r_num_out;
  assign bus.num_valid = r_num_valid;
  assign bus.digit_cnt = r_cnt;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_digit_entry_ctrl
// Purpose : Self-checking bench for digit_entry_ctrl (NDIG=4). A table of
//           single-cycle vectors covers the basic entry/commit/error flow;
//           hand-written sequences cover full entry, held keys, reset aborts,
//           and same-cycle control collisions. Expected codes follow
//           EXCESS3_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_digit_entry_ctrl;

`ifdef EXCESS3_EN
  localparam bit X3 = 1'b1;
`else
  localparam bit X3 = 1'b0;
`endif

  localparam logic [15:0] E16   = X3 ? 16'h3333 : 16'h0000;
  localparam logic [15:0] N1234 = X3 ? 16'h4567 : 16'h1234;
  localparam logic [15:0] N0090 = X3 ? 16'h33C3 : 16'h0090;
  localparam logic [15:0] N0008 = X3 ? 16'h333B : 16'h0008;

  logic clk;
  logic rst_n;

  digit_entry_ctrl_if #(.NDIG(4)) bus ();

  digit_entry_ctrl #(.NDIG(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  typedef struct {
    logic        rst_n;
    logic [9:0]  key;
    logic        kv;
    logic        clr;
    logic        ent;
    logic        ready;
    logic [15:0] out;
    logic        valid;
    logic [3:0]  cnt;
    logic        err;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(logic r, logic [9:0] key, logic kv, logic clr,
                              logic ent, logic ready, logic [15:0] out,
                              logic valid, logic [3:0] cnt, logic err);
    vec_t v;
    v.rst_n = r;   v.key = key;     v.kv = kv;   v.clr = clr; v.ent = ent;
    v.ready = ready; v.out = out;   v.valid = valid; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  function automatic logic [9:0] K(int k);
    logic [9:0] one;
    one = 10'd1;
    return one << k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(logic [9:0] key, logic kv, logic clr, logic ent);
    bus.key_in    = key;
    bus.key_valid = kv;
    bus.clear     = clr;
    bus.enter     = ent;
  endtask

  task automatic press(int k);
    drive(K(k), 1'b1, 1'b0, 1'b0);
    tick();
    drive(10'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(10'd0, 1'b0, 1'b0, 1'b0);

    //          rst key       kv clr ent | rdy out    vld cnt err
    tbl[0]  = mk(0, 10'd0,     0, 0, 0,   1, E16,   0, 0, 0);
    tbl[1]  = mk(1, K(1),      1, 0, 0,   0, E16,   0, 1, 0);
    tbl[2]  = mk(1, 10'd0,     0, 0, 0,   1, E16,   0, 1, 0);
    tbl[3]  = mk(1, K(2),      1, 0, 0,   0, E16,   0, 2, 0);
    tbl[4]  = mk(1, 10'd0,     0, 0, 0,   1, E16,   0, 2, 0);
    tbl[5]  = mk(1, K(3),      1, 0, 0,   0, E16,   0, 3, 0);
    tbl[6]  = mk(1, 10'd0,     0, 0, 0,   1, E16,   0, 3, 0);
    tbl[7]  = mk(1, K(4),      1, 0, 0,   0, E16,   0, 4, 0);
    tbl[8]  = mk(1, 10'd0,     0, 0, 0,   0, E16,   0, 4, 0);
    tbl[9]  = mk(1, 10'd0,     0, 0, 1,   0, E16,   0, 4, 0);
    tbl[10] = mk(1, 10'd0,     0, 0, 0,   1, N1234, 1, 0, 0);
    tbl[11] = mk(1, 10'd0,     0, 0, 0,   1, N1234, 0, 0, 0);
    tbl[12] = mk(1, K(9),      1, 0, 0,   0, N1234, 0, 1, 0);
    tbl[13] = mk(1, 10'd0,     0, 0, 0,   1, N1234, 0, 1, 0);
    tbl[14] = mk(1, K(0),      1, 0, 0,   0, N1234, 0, 2, 0);
    tbl[15] = mk(1, 10'd0,     0, 0, 0,   1, N1234, 0, 2, 0);
    tbl[16] = mk(1, 10'd0,     0, 0, 1,   0, N1234, 0, 2, 0);
    tbl[17] = mk(1, 10'd0,     0, 0, 0,   1, N0090, 1, 0, 0);
    tbl[18] = mk(1, 10'b11,    1, 0, 0,   0, N0090, 0, 0, 1);
    tbl[19] = mk(1, 10'd0,     0, 0, 0,   1, N0090, 0, 0, 1);
    tbl[20] = mk(1, 10'd0,     0, 1, 0,   1, N0090, 0, 0, 0);
    tbl[21] = mk(1, 10'd0,     1, 0, 0,   0, N0090, 0, 0, 1);
    tbl[22] = mk(1, 10'd0,     0, 1, 0,   1, N0090, 0, 0, 0);

    for (int i = 0; i < 23; i++) begin
      rst_n = tbl[i].rst_n;
      drive(tbl[i].key, tbl[i].kv, tbl[i].clr, tbl[i].ent);
      tick();
      chk($sformatf("v%0d.key_ready", i), 32'(bus.key_ready), 32'(tbl[i].ready));
      chk($sformatf("v%0d.num_out",   i), 32'(bus.num_out),   32'(tbl[i].out));
      chk($sformatf("v%0d.num_valid", i), 32'(bus.num_valid), 32'(tbl[i].valid));
      chk($sformatf("v%0d.digit_cnt", i), 32'(bus.digit_cnt), 32'(tbl[i].cnt));
      chk($sformatf("v%0d.err",       i), 32'(bus.err),       32'(tbl[i].err));
      $display("vec %0d key=%b kv=%b clr=%b ent=%b -> rdy=%b out=%h vld=%b cnt=%0d err=%b",
               i, tbl[i].key, tbl[i].kv, tbl[i].clr, tbl[i].ent, bus.key_ready,
               bus.num_out, bus.num_valid, bus.digit_cnt, bus.err);
    end
    drive(10'd0, 1'b0, 1'b0, 1'b0);

    // Fifth key on a full entry is refused.
    press(1); press(2); press(3); press(4);
    chk("full.ready_before", 32'(bus.key_ready), 32'd0);
    drive(K(5), 1'b1, 1'b0, 1'b0);
    tick();
    chk("full.cnt", 32'(bus.digit_cnt), 32'd4);
    chk("full.err", 32'(bus.err), 32'd0);
    chk("full.ready", 32'(bus.key_ready), 32'd0);
    drive(10'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(10'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(10'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("full.num_out", 32'(bus.num_out), 32'(N1234));
    chk("full.num_valid", 32'(bus.num_valid), 32'd1);
    $display("seq full: out=%h vld=%b", bus.num_out, bus.num_valid);

    // Key held five cycles yields exactly one digit.
    drive(K(7), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("held.cnt%0d", i), 32'(bus.digit_cnt), 32'd1);
    end
    drive(10'd0, 1'b0, 1'b0, 1'b0);
    tick();
    // clear and enter together: clear wins, no commit.
    drive(10'd0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("clr_ent.cnt", 32'(bus.digit_cnt), 32'd0);
    chk("clr_ent.valid0", 32'(bus.num_valid), 32'd0);
    drive(10'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("clr_ent.valid1", 32'(bus.num_valid), 32'd0);
    chk("clr_ent.num_out", 32'(bus.num_out), 32'(N1234));
    $display("seq held/clear+enter: cnt=%0d out=%h", bus.digit_cnt, bus.num_out);

    // Reset after two digits aborts everything.
    press(5); press(6);
    chk("rst2.cnt_before", 32'(bus.digit_cnt), 32'd2);
    rst_n = 1'b0;
    tick();
    chk("rst2.cnt", 32'(bus.digit_cnt), 32'd0);
    chk("rst2.num_out", 32'(bus.num_out), 32'(E16));
    chk("rst2.valid", 32'(bus.num_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst2.valid_after", 32'(bus.num_valid), 32'd0);
    $display("seq reset mid-entry: cnt=%0d out=%h", bus.digit_cnt, bus.num_out);

    // Key held across reset release is taken on the first clock.
    rst_n = 1'b0;
    drive(K(8), 1'b1, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rstkey.cnt", 32'(bus.digit_cnt), 32'd1);
    drive(10'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rstkey.ready", 32'(bus.key_ready), 32'd1);
    // enter with a key handshake: key ignored, commit 8; still held -> HOLD.
    drive(K(3), 1'b1, 1'b0, 1'b1);
    tick();
    chk("entkey.cnt", 32'(bus.digit_cnt), 32'd1);
    chk("entkey.err", 32'(bus.err), 32'd0);
    drive(K(3), 1'b1, 1'b0, 1'b0);
    tick();
    chk("entkey.valid", 32'(bus.num_valid), 32'd1);
    chk("entkey.num_out", 32'(bus.num_out), 32'(N0008));
    chk("entkey.cnt0", 32'(bus.digit_cnt), 32'd0);
    chk("entkey.ready_hold", 32'(bus.key_ready), 32'd0);
    drive(10'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("entkey.ready_idle", 32'(bus.key_ready), 32'd1);
    chk("entkey.cnt_idle", 32'(bus.digit_cnt), 32'd0);
    $display("seq reset-held key/enter+key: out=%h", bus.num_out);

    // enter in IDLE is ignored.
    drive(10'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(10'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("idle_ent.valid", 32'(bus.num_valid), 32'd0);
    chk("idle_ent.num_out", 32'(bus.num_out), 32'(N0008));
    $display("seq enter in idle: vld=%b out=%h", bus.num_valid, bus.num_out);

    // Reset during DONE: no pulse, result discarded.
    press(1);
    drive(10'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(10'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("rstdone.valid", 32'(bus.num_valid), 32'd0);
    chk("rstdone.num_out", 32'(bus.num_out), 32'(E16));
    rst_n = 1'b1;
    tick();
    chk("rstdone.valid_after", 32'(bus.num_valid), 32'd0);
    $display("seq reset in done: vld=%b out=%h", bus.num_valid, bus.num_out);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digit_entry_ctrl.md
DIGIT_ENTRY_CTRL -- requirements
Module: digit_entry_ctrl

Interface
REQ-001 Parameter: NDIG, 4, number of decimal digits accumulated (legal 1..8).
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 key_in  input  10  one-hot decimal key; bit k set = digit k.
REQ-005 key_valid  input  1  key pressed (level, held until release).
REQ-006 key_ready  output  1  controller can accept a key this cycle.
REQ-007 clear  input  1  discard entry in progress, clear err.
REQ-008 enter  input  1  commit current entry.
REQ-009 num_out  output  4*NDIG  last committed packed code, most significant digit in top nibble.
REQ-010 num_valid  output  1  one-cycle pulse when num_out updates.
REQ-011 digit_cnt  output  4  digits held in entry register (0..NDIG).
REQ-012 err  output  1  sticky flag: a non-one-hot key was accepted.

Function
REQ-013 States SHALL be IDLE (0 digits, armed), ARMED (1..NDIG-1 digits), HOLD (key accepted, waiting for release), FULL (NDIG digits, released), DONE (commit cycle).
REQ-014 key_ready SHALL be 1 only in IDLE and ARMED; handshake = key_valid && key_ready at a rising edge.
REQ-015 On handshake with exactly one key_in bit set: entry register shifts left 4, new digit code enters the low nibble, digit_cnt increments, next state HOLD.
REQ-016 On handshake with zero or multiple bits set: digit discarded, digit_cnt unchanged, err<=1, next state HOLD.
REQ-017 HOLD SHALL exit only on a cycle with key_valid=0: to FULL if digit_cnt==NDIG, else ARMED (IDLE if digit_cnt==0).
REQ-018 FULL SHALL refuse keys (key_ready=0) until enter or clear.
REQ-019 enter sampled high in ARMED, HOLD or FULL SHALL move to DONE next edge; enter in IDLE SHALL be ignored.
REQ-020 In DONE (one cycle): num_out<=entry register, num_valid=1, entry register<=empty code, digit_cnt<=0; next state HOLD if key_valid=1 else IDLE.
REQ-021 num_out SHALL hold its value except at the DONE edge.
REQ-022 Priority on the same edge: clear > enter > key handshake; clear resets entry register and digit_cnt, clears err, next state HOLD if key_valid=1 else IDLE; num_out unchanged.
REQ-023 enter and key handshake in the same cycle: key ignored, no err update.
REQ-024 Unfilled (leading) nibbles SHALL hold the empty code; digit codes SHALL be 4-bit per REQ-029/030.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force state IDLE, digit_cnt=0, err=0, num_valid=0, entry register and num_out = empty code repeated NDIG times.
REQ-026 Reset mid-entry or in DONE SHALL abort with no num_valid pulse.
REQ-027 key_valid held high when reset releases SHALL be accepted on the first clock (no release required).

Configuration
REQ-028 Macro EXCESS3_EN selects digit coding.
REQ-029 Without EXCESS3_EN: digit k coded as plain BCD k (0000..1001); empty code 0000.
REQ-030 With EXCESS3_EN: digit k coded as k+3 (0011..1100); empty code 0011; all other behaviour identical.

Verification
REQ-031 Reset, keys 1,2,3,4 each pressed and released, then enter -> num_out=16'h1234, num_valid one cycle, digit_cnt back to 0 (EXCESS3_EN: 16'h4567).
REQ-032 Keys 9,0 then enter -> num_out=16'h0090 (EXCESS3_EN: 16'h33C3).
REQ-033 Five keys 1..5 -> fifth key sees key_ready=0, FULL entered, enter -> num_out=16'h1234.
REQ-034 key_in=10'b0000000011 with key_valid -> err=1, digit_cnt unchanged; clear -> err=0.
REQ-035 key_valid held 5 cycles -> exactly one digit accepted; clear and enter same cycle -> no num_valid, num_out unchanged.
REQ-036 rst_n low after two digits -> digit_cnt=0, num_out=empty code, no num_valid.
